// File: rtl/button_debouncer.sv
// Multi-channel push-button/switch conditioner: two-flop synchronizer, per-channel
// stability counter, registered filtered level plus one-cycle rise/fall pulses.
module button_debouncer #(
  parameter int unsigned      WIDTH           = 1,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] INIT_VALUE      = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned     CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   ZERO_COUNT = {CW{1'b0}};
  localparam logic [CW-1:0]   ONE_COUNT  = CW'(1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] debounced_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [CW-1:0]    count_r [WIDTH];

  logic [WIDTH-1:0] debounced_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [CW-1:0]    count_s [WIDTH];

  // Synchronizer: only sync2_r is allowed to reach the filter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= INIT_VALUE;
      sync2_r <= INIT_VALUE;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  // Filter state register: counters, filtered level and edge pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      debounced_r <= INIT_VALUE;
      rise_r      <= {WIDTH{1'b0}};
      fall_r      <= {WIDTH{1'b0}};
      for (int i = 0; i < int'(WIDTH); i++) begin
        count_r[i] <= ZERO_COUNT;
      end
    end else begin
      debounced_r <= debounced_s;
      rise_r      <= rise_s;
      fall_r      <= fall_s;
      for (int i = 0; i < int'(WIDTH); i++) begin
        count_r[i] <= count_s[i];
      end
    end
  end

  // Next-state: any cycle matching the current level restarts the window,
  // so a single bounce sample discards all progress toward a change.
  always_comb begin
    debounced_s = debounced_r;
    rise_s      = {WIDTH{1'b0}};
    fall_s      = {WIDTH{1'b0}};
    for (int i = 0; i < int'(WIDTH); i++) begin
      count_s[i] = ZERO_COUNT;
      if (sync2_r[i] == debounced_r[i]) begin
        count_s[i] = ZERO_COUNT;
      end else if (count_r[i] == LAST_COUNT) begin
        count_s[i]     = ZERO_COUNT;
        debounced_s[i] = sync2_r[i];
        rise_s[i]      = sync2_r[i];
        fall_s[i]      = ~sync2_r[i];
      end else begin
        count_s[i] = count_r[i] + ONE_COUNT;
      end
    end
  end

  assign debounced = debounced_r;
  assign rise      = rise_r;
  assign fall      = fall_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: WIDTH=2, DEBOUNCE_CYCLES=8, plus a second
// instance with INIT_VALUE=2'b11 held at its reset level throughout.
module tb_button_debouncer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] raw_in = 2'b00;
  logic [1:0] debounced, rise, fall;
  logic [1:0] raw_in_b = 2'b11;
  logic [1:0] debounced_b, rise_b, fall_b;

  int n_assert = 0;
  int n_fail   = 0;
  int rise_cnt0 = 0, rise_cnt1 = 0, fall_cnt0 = 0, fall_cnt1 = 0;
  int pulse_cnt_b = 0;

  button_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(8), .INIT_VALUE(2'b00)) dut (
    .clock(clock), .reset_n(reset_n), .raw_in(raw_in),
    .debounced(debounced), .rise(rise), .fall(fall));

  button_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(8), .INIT_VALUE(2'b11)) dut_b (
    .clock(clock), .reset_n(reset_n), .raw_in(raw_in_b),
    .debounced(debounced_b), .rise(rise_b), .fall(fall_b));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then sample at the following falling edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
      rise_cnt0 += int'(rise[0]);
      rise_cnt1 += int'(rise[1]);
      fall_cnt0 += int'(fall[0]);
      fall_cnt1 += int'(fall[1]);
      pulse_cnt_b += int'(rise_b[0]) + int'(rise_b[1]) + int'(fall_b[0]) + int'(fall_b[1]);
      if ((rise & fall) != 2'b00) begin
        chk("rise_fall_exclusive", 32'(rise & fall), 32'd0);
      end
    end
  endtask

  task automatic clear_counts();
    rise_cnt0 = 0; rise_cnt1 = 0; fall_cnt0 = 0; fall_cnt1 = 0;
  endtask

  initial begin
    // reset state
    step(3);
    chk("reset_debounced", 32'(debounced), 32'd0);
    chk("reset_rise", 32'(rise), 32'd0);
    chk("reset_fall", 32'(fall), 32'd0);
    chk("init_b_in_reset", 32'(debounced_b), 32'h3);
    reset_n = 1'b1;
    step(3);
    chk("init_b_after_reset", 32'(debounced_b), 32'h3);
    clear_counts();

    // clean press on channel 0
    raw_in = 2'b01;
    step(9);
    chk("press_before_window", 32'(debounced), 32'd0);
    step(1);
    chk("press_debounced", 32'(debounced), 32'h1);
    chk("press_rise", 32'(rise), 32'h1);
    chk("press_fall", 32'(fall), 32'd0);
    step(1);
    chk("press_rise_one_cycle", 32'(rise), 32'd0);
    step(5);
    chk("press_rise_count", 32'(rise_cnt0), 32'd1);
    chk("press_fall_count", 32'(fall_cnt0), 32'd0);

    // release on channel 0
    raw_in = 2'b00;
    step(9);
    chk("release_before_window", 32'(debounced), 32'h1);
    step(1);
    chk("release_debounced", 32'(debounced), 32'd0);
    chk("release_fall", 32'(fall), 32'h1);
    step(3);
    clear_counts();

    // bounce: high 5, low 1, then high
    raw_in = 2'b01;
    step(5);
    chk("bounce_5_mark", 32'(debounced), 32'd0);
    raw_in = 2'b00;
    step(1);
    raw_in = 2'b01;
    step(9);
    chk("bounce_before_window", 32'(debounced), 32'd0);
    step(1);
    chk("bounce_debounced", 32'(debounced), 32'h1);
    step(5);
    chk("bounce_rise_count", 32'(rise_cnt0), 32'd1);
    raw_in = 2'b00;
    step(12);
    chk("bounce_released", 32'(debounced), 32'd0);
    clear_counts();

    // short glitch on channel 1: one cycle short of the window
    raw_in = 2'b10;
    step(7);
    raw_in = 2'b00;
    step(20);
    chk("glitch_debounced", 32'(debounced), 32'd0);
    chk("glitch_rise_count", 32'(rise_cnt1), 32'd0);
    chk("glitch_fall_count", 32'(fall_cnt1), 32'd0);

    // both channels together
    raw_in = 2'b11;
    step(9);
    chk("both_before_window", 32'(debounced), 32'd0);
    step(1);
    chk("both_debounced", 32'(debounced), 32'h3);
    chk("both_rise", 32'(rise), 32'h3);
    step(10);
    raw_in = 2'b00;
    step(9);
    chk("both_before_release", 32'(debounced), 32'h3);
    step(1);
    chk("both_released", 32'(debounced), 32'd0);
    chk("both_fall", 32'(fall), 32'h3);
    chk("both_rise_clear", 32'(rise), 32'd0);
    step(3);

    // reset while pending: channel 1 already high, channel 0 at count 5
    raw_in = 2'b10;
    step(10);
    chk("pre_reset_ch1", 32'(debounced), 32'h2);
    raw_in = 2'b11;
    step(7);
    clear_counts();
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_debounced", 32'(debounced), 32'd0);
    chk("async_reset_rise", 32'(rise), 32'd0);
    chk("async_reset_fall", 32'(fall), 32'd0);
    step(2);
    chk("in_reset_debounced", 32'(debounced), 32'd0);
    chk("in_reset_pulses", 32'(rise_cnt0 + rise_cnt1 + fall_cnt0 + fall_cnt1), 32'd0);
    reset_n = 1'b1;
    step(9);
    chk("post_reset_before_window", 32'(debounced), 32'd0);
    step(1);
    chk("post_reset_debounced", 32'(debounced), 32'h3);
    chk("post_reset_rise", 32'(rise), 32'h3);
    chk("post_reset_fall_count", 32'(fall_cnt0 + fall_cnt1), 32'd0);

    // INIT_VALUE=2'b11 instance never moved and never pulsed
    chk("init_b_final", 32'(debounced_b), 32'h3);
    chk("init_b_no_pulses", 32'(pulse_cnt_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
